// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: opcodes, field widths and FSM states.
// Optional LDI support is enabled by defining CPU_CTRL_LDI_EN.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int OPCODE_W  = 4;
  localparam int REG_SEL_W = 2;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_MOV = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_FETCH_IMM,
    ST_HALT
  } state_t;

  // Undefined opcodes execute as NOP but raise the illegal pulse.
  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_JZ, OP_HLT: legal = 1'b1;
`ifdef CPU_CTRL_LDI_EN
      OP_LDI: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the 8-bit CPU; arithmetic is modulo 256 with carry/borrow dropped.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   y,
  output logic                zero
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_MOV:  y = b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Define CPU_CTRL_LDI_EN to enable LDI rd,#imm (opcode 7) and the FETCH_IMM state.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                 clk,
  input  logic                 clr,
  output logic [DATA_W-1:0]    imem_addr,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic [DATA_W-1:0]    imem_data,
  output logic [REG_SEL_W-1:0] readreg1,
  output logic [REG_SEL_W-1:0] readreg2,
  output logic [REG_SEL_W-1:0] writereg,
  output logic                 regwrite,
  output logic [DATA_W-1:0]    data,
  input  logic [DATA_W-1:0]    read1,
  input  logic [DATA_W-1:0]    read2,
  output logic [DATA_W-1:0]    pc,
  output logic                 halted,
  output logic                 illegal
);

  state_t              state;
  state_t              next_state;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   result;
  logic                z;
  logic [OPCODE_W-1:0] opcode;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_zero;

  assign opcode   = ir[7:4];
  assign readreg1 = ir[3:2];
  assign readreg2 = ir[1:0];
  assign writereg = ir[3:2];
  assign data     = result;
  assign imem_addr = pc;

  // Strobes decode straight from state so clr removes them without waiting for a clock.
`ifdef CPU_CTRL_LDI_EN
  assign imem_req = (state == ST_FETCH) || (state == ST_FETCH_IMM);
`else
  assign imem_req = (state == ST_FETCH);
`endif
  assign regwrite = (state == ST_WRITEBACK);

  cpu_alu u_alu (
    .op   (opcode),
    .a    (read1),
    .b    (read2),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_BOOT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT:  next_state = ST_FETCH;
      ST_FETCH: if (imem_ack) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_JZ: next_state = ST_EXECUTE;
          OP_HLT: next_state = ST_HALT;
`ifdef CPU_CTRL_LDI_EN
          OP_LDI: next_state = ST_FETCH_IMM;
`endif
          default: next_state = ST_FETCH;
        endcase
      end
      ST_EXECUTE:   next_state = (opcode == OP_JZ) ? ST_FETCH : ST_WRITEBACK;
      ST_WRITEBACK: next_state = ST_FETCH;
`ifdef CPU_CTRL_LDI_EN
      ST_FETCH_IMM: if (imem_ack) next_state = ST_WRITEBACK;
`endif
      ST_HALT:      next_state = ST_HALT;
      default:      next_state = ST_BOOT;
    endcase
  end

  // The illegal flag is captured with the instruction so its pulse lines up with DECODE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc      <= RESET_PC;
      ir      <= '0;
      result  <= '0;
      z       <= 1'b0;
      illegal <= 1'b0;
      halted  <= 1'b0;
    end else begin
      illegal <= 1'b0;
      halted  <= (next_state == ST_HALT);
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir      <= imem_data;
            pc      <= pc + 8'd1;
            illegal <= ~op_is_legal(imem_data[7:4]);
          end
        end
        ST_EXECUTE: begin
          if (opcode == OP_JZ) begin
            if (z) pc <= read2;
          end else begin
            result <= alu_y;
            z      <= alu_zero;
          end
        end
`ifdef CPU_CTRL_LDI_EN
        ST_FETCH_IMM: begin
          if (imem_ack) begin
            result <= imem_data;
            pc     <= pc + 8'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed self-checking bench for cpu_control with a zero-wait memory model and a fixed register file.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [1:0] readreg1;
  logic [1:0] readreg2;
  logic [1:0] writereg;
  logic       regwrite;
  logic [7:0] data;
  logic [7:0] read1;
  logic [7:0] read2;
  logic [7:0] pc;
  logic       halted;
  logic       illegal;

  logic [7:0] imem [256];
  logic [7:0] rf [4];
  logic       ack_en = 1'b1;
  int         tests_run = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  assign imem_ack  = imem_req & ack_en;
  assign imem_data = imem[imem_addr];
  assign read1     = rf[readreg1];
  assign read2     = rf[readreg2];

  cpu_control #(.RESET_PC(8'h10)) dut (
    .clk       (clk),
    .clr       (clr),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .readreg1  (readreg1),
    .readreg2  (readreg2),
    .writereg  (writereg),
    .regwrite  (regwrite),
    .data      (data),
    .read1     (read1),
    .read2     (read2),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    ack_en = 1'b1;
  endtask

  // Leaves the caller at the negedge where clr falls (the BOOT cycle).
  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    ack_en = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    tests_run++; if (regwrite !== 1'b0) begin fails++; $display("[TB] FAIL reset_regwrite: got %b expected 0", regwrite); end
    tests_run++; if (pc !== 8'h10 || imem_addr !== 8'h10) begin fails++; $display("[TB] FAIL reset_pc: got pc=%h addr=%h expected 10", pc, imem_addr); end
    tests_run++; if ({data, readreg1, readreg2, writereg, halted, illegal} !== 16'h0000) begin fails++; $display("[TB] FAIL reset_misc: got data=%h rr1=%h rr2=%h wr=%h halted=%b illegal=%b expected all 0", data, readreg1, readreg2, writereg, halted, illegal); end
    clr = 1'b0;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL boot_req: got %b expected 0", imem_req); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin fails++; $display("[TB] FAIL first_fetch: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr); end
  endtask

  task automatic test_add();
    clear_mem();
    rf[0] = 8'h03; rf[1] = 8'hFF;
    imem[8'h10] = 8'h11; imem[8'h11] = 8'h61; imem[8'h12] = 8'hF0;
    do_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (readreg1 !== 2'd0 || readreg2 !== 2'd1) begin fails++; $display("[TB] FAIL add_selects: got rr1=%0d rr2=%0d expected 0 1", readreg1, readreg2); end
    repeat (2) @(negedge clk);
    tests_run++; if (regwrite !== 1'b1 || writereg !== 2'd0 || data !== 8'h02) begin fails++; $display("[TB] FAIL add_writeback: got rw=%b wr=%0d data=%h expected rw=1 wr=0 data=02", regwrite, writereg, data); end
    @(negedge clk);
    tests_run++; if (regwrite !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h11) begin fails++; $display("[TB] FAIL add_next_fetch: got rw=%b req=%b addr=%h expected rw=0 req=1 addr=11", regwrite, imem_req, imem_addr); end
    repeat (3) @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 8'h12) begin fails++; $display("[TB] FAIL add_jz_not_taken: got req=%b addr=%h expected req=1 addr=12", imem_req, imem_addr); end
  endtask

  task automatic test_alu_ops();
    logic [7:0] instr [5];
    logic [7:0] expv [5];
    instr[0] = 8'h16; expv[0] = 8'h1D;
    instr[1] = 8'h26; expv[1] = 8'h69;
    instr[2] = 8'h36; expv[2] = 8'h42;
    instr[3] = 8'h46; expv[3] = 8'hDB;
    instr[4] = 8'h56; expv[4] = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      clear_mem();
      rf[1] = 8'hC3; rf[2] = 8'h5A;
      imem[8'h10] = instr[k]; imem[8'h11] = 8'hF0;
      do_reset();
      repeat (4) @(negedge clk);
      tests_run++; if (regwrite !== 1'b1 || writereg !== 2'd1 || data !== expv[k]) begin fails++; $display("[TB] FAIL alu_op%0d: got rw=%b wr=%0d data=%h expected rw=1 wr=1 data=%h", k, regwrite, writereg, data, expv[k]); end
    end
  endtask

  task automatic test_sub_jz();
    clear_mem();
    rf[2] = 8'h55; rf[3] = 8'h40;
    imem[8'h10] = 8'h2A; imem[8'h11] = 8'h63; imem[8'h40] = 8'hF0;
    do_reset();
    repeat (4) @(negedge clk);
    tests_run++; if (regwrite !== 1'b1 || writereg !== 2'd2 || data !== 8'h00) begin fails++; $display("[TB] FAIL sub_writeback: got rw=%b wr=%0d data=%h expected rw=1 wr=2 data=00", regwrite, writereg, data); end
    repeat (4) @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || pc !== 8'h40) begin fails++; $display("[TB] FAIL jz_taken: got req=%b addr=%h pc=%h expected req=1 addr=40 pc=40", imem_req, imem_addr, pc); end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    rf[3] = 8'hFF;
    imem[8'h10] = 8'h2A; imem[8'h11] = 8'h63; imem[8'hFF] = 8'h00; imem[8'h00] = 8'hF0;
    do_reset();
    repeat (8) @(negedge clk);
    tests_run++; if (imem_addr !== 8'hFF) begin fails++; $display("[TB] FAIL wrap_jump: got addr=%h expected ff", imem_addr); end
    @(negedge clk);
    tests_run++; if (pc !== 8'h00) begin fails++; $display("[TB] FAIL wrap_pc: got pc=%h expected 00", pc); end
  endtask

  task automatic test_wait_states();
    int bad;
    clear_mem();
    imem[8'h10] = 8'h00; imem[8'h11] = 8'hF0;
    ack_en = 1'b0;
    do_reset();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== 8'h10 || pc !== 8'h10) bad++;
    end
    tests_run++; if (bad !== 0) begin fails++; $display("[TB] FAIL wait_stable: got %0d unstable cycles expected 0", bad); end
    ack_en = 1'b1;
    @(negedge clk);
    tests_run++; if (pc !== 8'h11 || imem_req !== 1'b0) begin fails++; $display("[TB] FAIL wait_ack: got pc=%h req=%b expected pc=11 req=0", pc, imem_req); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 8'h11) begin fails++; $display("[TB] FAIL nop_cycles: got req=%b addr=%h expected req=1 addr=11", imem_req, imem_addr); end
  endtask

  task automatic test_illegal();
    clear_mem();
    imem[8'h10] = 8'h90; imem[8'h11] = 8'hF0;
    do_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (illegal !== 1'b1) begin fails++; $display("[TB] FAIL illegal_pulse: got %b expected 1", illegal); end
    @(negedge clk);
    tests_run++; if (illegal !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h11) begin fails++; $display("[TB] FAIL illegal_end: got ill=%b req=%b addr=%h expected ill=0 req=1 addr=11", illegal, imem_req, imem_addr); end
  endtask

  task automatic test_ldi();
    int writes;
    clear_mem();
    imem[8'h10] = 8'h74; imem[8'h11] = 8'hA5; imem[8'h12] = 8'hF0;
    do_reset();
`ifdef CPU_CTRL_LDI_EN
    repeat (2) @(negedge clk);
    tests_run++; if (illegal !== 1'b0) begin fails++; $display("[TB] FAIL ldi_legal: got %b expected 0", illegal); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 8'h11) begin fails++; $display("[TB] FAIL ldi_imm_fetch: got req=%b addr=%h expected req=1 addr=11", imem_req, imem_addr); end
    @(negedge clk);
    tests_run++; if (regwrite !== 1'b1 || writereg !== 2'd1 || data !== 8'hA5) begin fails++; $display("[TB] FAIL ldi_writeback: got rw=%b wr=%0d data=%h expected rw=1 wr=1 data=a5", regwrite, writereg, data); end
    @(negedge clk);
    tests_run++; if (imem_addr !== 8'h12 || imem_req !== 1'b1) begin fails++; $display("[TB] FAIL ldi_next: got req=%b addr=%h expected req=1 addr=12", imem_req, imem_addr); end
`else
    @(negedge clk);
    writes = (regwrite === 1'b1) ? 1 : 0;
    @(negedge clk);
    tests_run++; if (illegal !== 1'b1) begin fails++; $display("[TB] FAIL ldi_illegal: got %b expected 1", illegal); end
    for (int i = 0; i < 5; i++) begin
      if (regwrite === 1'b1) writes++;
      @(negedge clk);
    end
    tests_run++; if (writes !== 0) begin fails++; $display("[TB] FAIL ldi_no_write: got %0d writes expected 0", writes); end
`endif
  endtask

  task automatic test_halt();
    int bad;
    clear_mem();
    imem[8'h10] = 8'hF0;
    do_reset();
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || imem_req !== 1'b0 || regwrite !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++; if (bad !== 0) begin fails++; $display("[TB] FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
    tests_run++; if (pc !== 8'h11) begin fails++; $display("[TB] FAIL halt_pc: got %h expected 11", pc); end
  endtask

  task automatic test_clr_abort();
    clear_mem();
    rf[0] = 8'h03; rf[1] = 8'hFF;
    imem[8'h10] = 8'h11;
    do_reset();
    repeat (4) @(negedge clk);
    tests_run++; if (regwrite !== 1'b1) begin fails++; $display("[TB] FAIL abort_pre: got rw=%b expected 1", regwrite); end
    #2 clr = 1'b1;
    #1;
    tests_run++; if (regwrite !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h10 || data !== 8'h00) begin fails++; $display("[TB] FAIL abort_async: got rw=%b req=%b pc=%h data=%h expected 0 0 10 00", regwrite, imem_req, pc, data); end
    @(negedge clk);
    clr = 1'b0;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL abort_boot: got req=%b expected 0", imem_req); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin fails++; $display("[TB] FAIL abort_restart: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_sub_jz();
    test_pc_wrap();
    test_wait_states();
    test_illegal();
    test_ldi();
    test_halt();
    test_clr_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multi-cycle fetch/decode/execute sequencer for the simple 8-bit CPU. It fetches 8-bit instructions over a req/ack instruction-memory handshake, drives the register file's read/write selects and write data, and computes ALU results internally. It sits directly upstream of the register file and consumes the file's two combinational read ports.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset.
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  reset, asynchronous, active-high; shared with the register file's clear.
- imem_addr  out  8  fetch address (= pc).
- imem_req  out  1  fetch request; held until acknowledged.
- imem_ack  in  1  memory acknowledge; imem_data valid in the same cycle.
- imem_data  in  8  instruction or immediate byte.
- readreg1  out  2  = ir[3:2] (rd).
- readreg2  out  2  = ir[1:0] (rs).
- writereg  out  2  = ir[3:2].
- regwrite  out  1  register-file write enable.
- data  out  8  write data to the register file (result register).
- read1, read2  in  8  register-file read ports.
- pc  out  8  current program counter.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Instruction format: ir[7:4] opcode, ir[3:2] rd, ir[1:0] rs.
- Opcodes: 0 NOP; 1 ADD rd<=rd+rs; 2 SUB rd<=rd-rs; 3 AND; 4 OR; 5 MOV rd<=rs; 6 JZ (if z, pc<=read2); 7 LDI (see Configuration); F HLT. All others: NOP with an illegal pulse in DECODE.
- Arithmetic is modulo 256. Carry and borrow are discarded.
- z flag: updated in EXECUTE by ADD/SUB/AND/OR/MOV (result==0). Unchanged by other opcodes. Reset value 0.
- States: BOOT -> FETCH.
  - FETCH: req=1; stays until ack. On ack: ir<=imem_data, pc<=pc+1, go to DECODE.
  - DECODE: branches by opcode.
    - ALU/MOV/JZ -> EXECUTE.
    - NOP/illegal -> FETCH.
    - HLT -> HALT.
    - LDI -> FETCH_IMM.
  - EXECUTE: ALU -> WRITEBACK. JZ -> FETCH.
  - WRITEBACK: regwrite=1 for the full cycle. The register file captures on the mid-cycle negedge. Go to FETCH.
  - HALT: sticky until clr. No requests, regwrite=0.
- pc wraps from 8'hFF to 8'h00.
- imem_ack is ignored when imem_req=0.

## Timing
- While clr is high, all outputs are 0 except pc=RESET_PC and imem_addr=RESET_PC. State=BOOT, ir=0, z=0, result=0.
- clr asserted mid-operation aborts immediately. regwrite and imem_req drop asynchronously and no write occurs.
- BOOT lasts one cycle after clr falls. imem_req first rises in the following cycle.
- imem_req and regwrite are Moore outputs decoded from state. All other outputs are registered or drawn directly from ir.
- Cycle counts with zero-wait memory (ack in the first FETCH cycle):
  - ALU/MOV: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - JZ: 3 cycles.
  - NOP: 2 cycles.
  - LDI: 4 cycles.
  - Each wait cycle adds 1.
- JZ taken: the new pc is visible on imem_addr in the next FETCH cycle.

## Configuration
- CPU_CTRL_LDI_EN defined:
  - Opcode 7 = LDI rd, #imm.
  - DECODE -> FETCH_IMM (req at pc). On ack: result<=imem_data, pc<=pc+1, go to WRITEBACK.
  - z is not updated.
- CPU_CTRL_LDI_EN undefined: the FETCH_IMM state is absent, and opcode 7 is illegal (NOP + pulse).

## Structure
- Package cpu_pkg holds:
  - opcode localparams.
  - state encoding (BOOT, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH_IMM, HALT).
  - instruction field widths.
- One sub-module, cpu_alu: combinational (op, a, b) -> (y, zero). Instantiated in cpu_control.

## Test plan
- Reset release with RESET_PC=8'h10 -> BOOT for 1 cycle, then imem_req=1 with imem_addr=8'h10. All other outputs 0.
- With R0=8'h03 and R1=8'hFF, ADD r0,r1 (8'h11) -> regwrite high for 1 cycle, writereg=0, data=8'h02, z=0.
- SUB r2,r2 (8'h2A), then JZ r3 (8'h63) with R3=8'h40 -> z=1, and the next imem_addr=8'h40.
- Hold imem_ack low for 3 cycles -> imem_req and imem_addr stay stable, and pc increments only once, on ack.
- LDI r1,#8'hA5 (8'h74, 8'hA5) with the macro defined -> data=8'hA5 and writereg=1. Without the macro -> illegal pulse and no regwrite.
- HLT (8'hF0) -> halted=1 and no requests for 20 cycles. Asserting clr mid-WRITEBACK drops regwrite immediately and restarts from BOOT.
